// File: rtl/ysyx_24110006_arb_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_arb_pkg
// Shared definitions for the two-master AXI4 arbiter:
//   - read FSM states  (RD_IDLE / RD_ADDR / RD_DATA)
//   - write FSM states (WR_IDLE / WR_ADDR / WR_DATA / WR_RESP)
//   - one-hot grant encodings and a helper turning an owner index into one.
// ---------------------------------------------------------------------------
package ysyx_24110006_arb_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } wr_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  function automatic logic [1:0] gnt_of(input logic owner);
    return owner ? GNT_M1 : GNT_M0;
  endfunction

endpackage

// File: rtl/ysyx_24110006_arb_pick.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_arb_pick
// Combinational two-way requester picker.
//   Build option AXI_ARB_RR_EN:
//     defined   - round-robin: on a tie the master that did not win last time
//                 is picked; a last-winner register (reset to master 1, so
//                 master 0 wins the first tie) updates whenever 'update' is
//                 high and some master requests.
//     undefined - fixed priority, master 0 always wins; no state is kept.
// Ports:
//   clock, reset_n, update (round-robin build only) : clock, sync active-low
//                                                     reset, grant strobe
//   req  [1:0] : request vector, bit N = master N
//   pick [1:0] : one-hot selected master, 0 when nobody requests
// ---------------------------------------------------------------------------
module ysyx_24110006_arb_pick
  import ysyx_24110006_arb_pkg::*;
(
`ifdef AXI_ARB_RR_EN
  input  logic       clock,
  input  logic       reset_n,
  input  logic       update,
`endif
  input  logic [1:0] req,
  output logic [1:0] pick
);

`ifdef AXI_ARB_RR_EN
  logic last;  // index of the previous winner

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last <= 1'b1;
    end else if (update && (req != 2'b00)) begin
      last <= pick[1];
    end
  end

  always_comb begin
    pick = GNT_NONE;
    unique case (req)
      2'b01:   pick = GNT_M0;
      2'b10:   pick = GNT_M1;
      2'b11:   pick = last ? GNT_M0 : GNT_M1;
      default: pick = GNT_NONE;
    endcase
  end
`else
  always_comb begin
    pick = GNT_NONE;
    if (req[0]) begin
      pick = GNT_M0;
    end else if (req[1]) begin
      pick = GNT_M1;
    end
  end
`endif

endmodule

// File: rtl/ysyx_24110006_axi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_axi_rr_arbiter
// Shares one downstream AXI4 port between the IFU (master 0) and the LSU
// (master 1). Read and write channels are arbitrated by two independent FSMs;
// each holds its grant from the address handshake through the last R beat /
// the B handshake. Every output toward a non-owner is forced to zero, and the
// downstream bundle is zero outside the phase that routes it.
// Read bursts are length-checked: o_rerr pulses (combinationally, on the beat
// handshake) when rlast disagrees with the beat count versus the latched arlen.
// Build option AXI_ARB_RR_EN: round-robin tie-break when defined, fixed
// priority to master 0 otherwise.
// Ports:
//   i_clock, i_reset_n         : clock, synchronous active-low reset
//   i_axi_ar*/rready{0,1}      : master read requests; o_axi_arready/r*{0,1}
//   i_axi_aw*/w*/bready{0,1}   : master write requests; o_axi_awready/wready/b*{0,1}
//   o_axi_ar*/aw*/w*/rready/bready, i_axi_arready/awready/wready/r*/b* : downstream
//   o_rerr                     : burst length mismatch pulse
//   o_rgnt / o_wgnt            : one-hot read / write owner, 0 when idle
// ---------------------------------------------------------------------------
module ysyx_24110006_axi_rr_arbiter
  import ysyx_24110006_arb_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  // master 0 read
  input  logic [31:0]           i_axi_araddr0,
  input  logic                  i_axi_arvalid0,
  input  logic [ID_W-1:0]       i_axi_arid0,
  input  logic [7:0]            i_axi_arlen0,
  input  logic [2:0]            i_axi_arsize0,
  input  logic [1:0]            i_axi_arburst0,
  input  logic                  i_axi_rready0,
  output logic                  o_axi_arready0,
  output logic [DATA_W-1:0]     o_axi_rdata0,
  output logic                  o_axi_rvalid0,
  output logic [1:0]            o_axi_rresp0,
  output logic [ID_W-1:0]       o_axi_rid0,
  output logic                  o_axi_rlast0,
  // master 1 read
  input  logic [31:0]           i_axi_araddr1,
  input  logic                  i_axi_arvalid1,
  input  logic [ID_W-1:0]       i_axi_arid1,
  input  logic [7:0]            i_axi_arlen1,
  input  logic [2:0]            i_axi_arsize1,
  input  logic [1:0]            i_axi_arburst1,
  input  logic                  i_axi_rready1,
  output logic                  o_axi_arready1,
  output logic [DATA_W-1:0]     o_axi_rdata1,
  output logic                  o_axi_rvalid1,
  output logic [1:0]            o_axi_rresp1,
  output logic [ID_W-1:0]       o_axi_rid1,
  output logic                  o_axi_rlast1,
  // master 0 write
  input  logic [31:0]           i_axi_awaddr0,
  input  logic                  i_axi_awvalid0,
  input  logic [ID_W-1:0]       i_axi_awid0,
  input  logic [7:0]            i_axi_awlen0,
  input  logic [2:0]            i_axi_awsize0,
  input  logic [1:0]            i_axi_awburst0,
  input  logic [DATA_W-1:0]     i_axi_wdata0,
  input  logic [DATA_W/8-1:0]   i_axi_wstrb0,
  input  logic                  i_axi_wvalid0,
  input  logic                  i_axi_wlast0,
  input  logic                  i_axi_bready0,
  output logic                  o_axi_awready0,
  output logic                  o_axi_wready0,
  output logic [1:0]            o_axi_bresp0,
  output logic                  o_axi_bvalid0,
  output logic [ID_W-1:0]       o_axi_bid0,
  // master 1 write
  input  logic [31:0]           i_axi_awaddr1,
  input  logic                  i_axi_awvalid1,
  input  logic [ID_W-1:0]       i_axi_awid1,
  input  logic [7:0]            i_axi_awlen1,
  input  logic [2:0]            i_axi_awsize1,
  input  logic [1:0]            i_axi_awburst1,
  input  logic [DATA_W-1:0]     i_axi_wdata1,
  input  logic [DATA_W/8-1:0]   i_axi_wstrb1,
  input  logic                  i_axi_wvalid1,
  input  logic                  i_axi_wlast1,
  input  logic                  i_axi_bready1,
  output logic                  o_axi_awready1,
  output logic                  o_axi_wready1,
  output logic [1:0]            o_axi_bresp1,
  output logic                  o_axi_bvalid1,
  output logic [ID_W-1:0]       o_axi_bid1,
  // downstream read
  output logic [31:0]           o_axi_araddr,
  output logic                  o_axi_arvalid,
  output logic [ID_W-1:0]       o_axi_arid,
  output logic [7:0]            o_axi_arlen,
  output logic [2:0]            o_axi_arsize,
  output logic [1:0]            o_axi_arburst,
  output logic                  o_axi_rready,
  input  logic                  i_axi_arready,
  input  logic [DATA_W-1:0]     i_axi_rdata,
  input  logic                  i_axi_rvalid,
  input  logic [1:0]            i_axi_rresp,
  input  logic [ID_W-1:0]       i_axi_rid,
  input  logic                  i_axi_rlast,
  // downstream write
  output logic [31:0]           o_axi_awaddr,
  output logic                  o_axi_awvalid,
  output logic [ID_W-1:0]       o_axi_awid,
  output logic [7:0]            o_axi_awlen,
  output logic [2:0]            o_axi_awsize,
  output logic [1:0]            o_axi_awburst,
  output logic [DATA_W-1:0]     o_axi_wdata,
  output logic [DATA_W/8-1:0]   o_axi_wstrb,
  output logic                  o_axi_wvalid,
  output logic                  o_axi_wlast,
  output logic                  o_axi_bready,
  input  logic                  i_axi_awready,
  input  logic                  i_axi_wready,
  input  logic [1:0]            i_axi_bresp,
  input  logic                  i_axi_bvalid,
  input  logic [ID_W-1:0]       i_axi_bid,
  // status
  output logic                  o_rerr,
  output logic [1:0]            o_rgnt,
  output logic [1:0]            o_wgnt
);

  // ---------------------------------------------------------------- read side
  rd_state_t  rd_state, rd_next;
  logic       rd_owner;          // 0 = master 0, 1 = master 1
  logic [7:0] arlen_q;
  logic [7:0] beat_cnt;
  logic [1:0] rd_pick;
  logic       rd_idle, rd_addr_ph, rd_data_ph, r_sel0, r_sel1;
  logic       ar_hs, r_hs;

  assign rd_idle    = (rd_state == RD_IDLE);
  assign rd_addr_ph = (rd_state == RD_ADDR);
  assign rd_data_ph = (rd_state == RD_DATA);
  assign r_sel0     = rd_data_ph && !rd_owner;
  assign r_sel1     = rd_data_ph &&  rd_owner;

  ysyx_24110006_arb_pick u_rd_pick (
`ifdef AXI_ARB_RR_EN
    .clock   (i_clock),
    .reset_n (i_reset_n),
    .update  (rd_idle),
`endif
    .req     ({i_axi_arvalid1, i_axi_arvalid0}),
    .pick    (rd_pick)
  );

  assign o_axi_araddr  = rd_addr_ph ? (rd_owner ? i_axi_araddr1  : i_axi_araddr0)  : '0;
  assign o_axi_arvalid = rd_addr_ph && (rd_owner ? i_axi_arvalid1 : i_axi_arvalid0);
  assign o_axi_arid    = rd_addr_ph ? (rd_owner ? i_axi_arid1    : i_axi_arid0)    : '0;
  assign o_axi_arlen   = rd_addr_ph ? (rd_owner ? i_axi_arlen1   : i_axi_arlen0)   : '0;
  assign o_axi_arsize  = rd_addr_ph ? (rd_owner ? i_axi_arsize1  : i_axi_arsize0)  : '0;
  assign o_axi_arburst = rd_addr_ph ? (rd_owner ? i_axi_arburst1 : i_axi_arburst0) : '0;
  assign o_axi_arready0 = rd_addr_ph && !rd_owner && i_axi_arready;
  assign o_axi_arready1 = rd_addr_ph &&  rd_owner && i_axi_arready;

  assign o_axi_rready  = rd_data_ph && (rd_owner ? i_axi_rready1 : i_axi_rready0);
  assign o_axi_rdata0  = r_sel0 ? i_axi_rdata : '0;
  assign o_axi_rvalid0 = r_sel0 && i_axi_rvalid;
  assign o_axi_rresp0  = r_sel0 ? i_axi_rresp : '0;
  assign o_axi_rid0    = r_sel0 ? i_axi_rid   : '0;
  assign o_axi_rlast0  = r_sel0 && i_axi_rlast;
  assign o_axi_rdata1  = r_sel1 ? i_axi_rdata : '0;
  assign o_axi_rvalid1 = r_sel1 && i_axi_rvalid;
  assign o_axi_rresp1  = r_sel1 ? i_axi_rresp : '0;
  assign o_axi_rid1    = r_sel1 ? i_axi_rid   : '0;
  assign o_axi_rlast1  = r_sel1 && i_axi_rlast;

  assign ar_hs = o_axi_arvalid && i_axi_arready;
  assign r_hs  = i_axi_rvalid && o_axi_rready;

  // A beat is in error when "this is the last beat by count" and rlast
  // disagree; the grant is still held until rlast actually arrives.
  assign o_rerr = r_hs && (i_axi_rlast != (beat_cnt == arlen_q));
  assign o_rgnt = rd_idle ? GNT_NONE : gnt_of(rd_owner);

  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      RD_IDLE: if (rd_pick != GNT_NONE)  rd_next = RD_ADDR;
      RD_ADDR: if (ar_hs)                rd_next = RD_DATA;
      RD_DATA: if (r_hs && i_axi_rlast)  rd_next = RD_IDLE;
      default:                           rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      rd_state <= RD_IDLE;
      rd_owner <= 1'b0;
      beat_cnt <= 8'd0;
    end else begin
      rd_state <= rd_next;
      if (rd_idle && (rd_pick != GNT_NONE)) begin
        rd_owner <= rd_pick[1];
      end
      if (ar_hs) begin
        beat_cnt <= 8'd0;
      end else if (r_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  // Burst length is data, only meaningful once captured on the AR handshake.
  always_ff @(posedge i_clock) begin
    if (ar_hs) begin
      arlen_q <= o_axi_arlen;
    end
  end

  // --------------------------------------------------------------- write side
  wr_state_t  wr_state, wr_next;
  logic       wr_owner;
  logic [1:0] wr_pick;
  logic       wr_idle, wr_addr_ph, wr_data_ph, wr_resp_ph, b_sel0, b_sel1;
  logic       aw_hs, wlast_hs, b_hs;

  assign wr_idle    = (wr_state == WR_IDLE);
  assign wr_addr_ph = (wr_state == WR_ADDR);
  assign wr_data_ph = (wr_state == WR_DATA);
  assign wr_resp_ph = (wr_state == WR_RESP);
  assign b_sel0     = wr_resp_ph && !wr_owner;
  assign b_sel1     = wr_resp_ph &&  wr_owner;

  ysyx_24110006_arb_pick u_wr_pick (
`ifdef AXI_ARB_RR_EN
    .clock   (i_clock),
    .reset_n (i_reset_n),
    .update  (wr_idle),
`endif
    .req     ({i_axi_awvalid1, i_axi_awvalid0}),
    .pick    (wr_pick)
  );

  assign o_axi_awaddr  = wr_addr_ph ? (wr_owner ? i_axi_awaddr1  : i_axi_awaddr0)  : '0;
  assign o_axi_awvalid = wr_addr_ph && (wr_owner ? i_axi_awvalid1 : i_axi_awvalid0);
  assign o_axi_awid    = wr_addr_ph ? (wr_owner ? i_axi_awid1    : i_axi_awid0)    : '0;
  assign o_axi_awlen   = wr_addr_ph ? (wr_owner ? i_axi_awlen1   : i_axi_awlen0)   : '0;
  assign o_axi_awsize  = wr_addr_ph ? (wr_owner ? i_axi_awsize1  : i_axi_awsize0)  : '0;
  assign o_axi_awburst = wr_addr_ph ? (wr_owner ? i_axi_awburst1 : i_axi_awburst0) : '0;
  assign o_axi_awready0 = wr_addr_ph && !wr_owner && i_axi_awready;
  assign o_axi_awready1 = wr_addr_ph &&  wr_owner && i_axi_awready;

  // W is only routed once the address is accepted (AW-first masters only).
  assign o_axi_wdata   = wr_data_ph ? (wr_owner ? i_axi_wdata1 : i_axi_wdata0) : '0;
  assign o_axi_wstrb   = wr_data_ph ? (wr_owner ? i_axi_wstrb1 : i_axi_wstrb0) : '0;
  assign o_axi_wvalid  = wr_data_ph && (wr_owner ? i_axi_wvalid1 : i_axi_wvalid0);
  assign o_axi_wlast   = wr_data_ph && (wr_owner ? i_axi_wlast1  : i_axi_wlast0);
  assign o_axi_wready0 = wr_data_ph && !wr_owner && i_axi_wready;
  assign o_axi_wready1 = wr_data_ph &&  wr_owner && i_axi_wready;

  assign o_axi_bready  = wr_resp_ph && (wr_owner ? i_axi_bready1 : i_axi_bready0);
  assign o_axi_bresp0  = b_sel0 ? i_axi_bresp : '0;
  assign o_axi_bvalid0 = b_sel0 && i_axi_bvalid;
  assign o_axi_bid0    = b_sel0 ? i_axi_bid   : '0;
  assign o_axi_bresp1  = b_sel1 ? i_axi_bresp : '0;
  assign o_axi_bvalid1 = b_sel1 && i_axi_bvalid;
  assign o_axi_bid1    = b_sel1 ? i_axi_bid   : '0;

  assign aw_hs    = o_axi_awvalid && i_axi_awready;
  assign wlast_hs = o_axi_wvalid && i_axi_wready && o_axi_wlast;
  assign b_hs     = i_axi_bvalid && o_axi_bready;

  assign o_wgnt = wr_idle ? GNT_NONE : gnt_of(wr_owner);

  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      WR_IDLE: if (wr_pick != GNT_NONE) wr_next = WR_ADDR;
      WR_ADDR: if (aw_hs)               wr_next = WR_DATA;
      WR_DATA: if (wlast_hs)            wr_next = WR_RESP;
      WR_RESP: if (b_hs)                wr_next = WR_IDLE;
      default:                          wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      wr_state <= WR_IDLE;
      wr_owner <= 1'b0;
    end else begin
      wr_state <= wr_next;
      if (wr_idle && (wr_pick != GNT_NONE)) begin
        wr_owner <= wr_pick[1];
      end
    end
  end

endmodule
